// File: rtl/dbus_pkg.sv
// Shared data-bus transaction types.
//   dbus_req_t  : valid, addr, size, strobe, data (one request beat)
//   dbus_resp_t : addr_ok, data_ok, data (one response beat)
package dbus_pkg;

    localparam logic [2:0] MSIZE1 = 3'd0;
    localparam logic [2:0] MSIZE2 = 3'd1;
    localparam logic [2:0] MSIZE4 = 3'd2;
    localparam logic [2:0] MSIZE8 = 3'd3;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [63:0] data;
    } dbus_resp_t;

endpackage

// File: rtl/dbus_arbiter.sv
// Two-requester data-bus arbiter.
//
// Shares one downstream data bus between port 0 (memory stage) and port 1
// (secondary requester). The winning request is latched and presented on
// oreq from the following cycle until the downstream returns data_ok.
// Ties are broken round-robin using the last-granted pointer.
//
// Ports:
//   clk    : clock
//   reset  : synchronous active-high reset
//   dreq0  : request from port 0        dresp0 : response to port 0
//   dreq1  : request from port 1        dresp1 : response to port 1
//   oreq   : request to downstream bus  oresp  : response from downstream
//   busy   : high while a transaction is outstanding (state BUSY)
//
// Handshake: a requester raises valid and holds it and its fields until it
// sees data_ok. The arbiter holds oreq.valid and the latched fields from the
// first BUSY cycle through the cycle in which oresp.data_ok is seen; that
// cycle retires the transaction and the next cycle is always IDLE.
module dbus_arbiter
    import dbus_pkg::*;
#(
    parameter logic INIT_LAST = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  dbus_req_t  dreq0,
    output dbus_resp_t dresp0,
    input  dbus_req_t  dreq1,
    output dbus_resp_t dresp1,
    output dbus_req_t  oreq,
    input  dbus_resp_t oresp,
    output logic       busy
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t    state, state_n;
    logic      gnt, gnt_n;
    logic      last, last_n;
    dbus_req_t req_q, req_n;
    logic      pick1;
    logic      req_live;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            gnt   <= 1'b0;
            last  <= INIT_LAST;
            req_q <= '0;
        end else begin
            state <= state_n;
            gnt   <= gnt_n;
            last  <= last_n;
            req_q <= req_n;
        end
    end

    always_comb begin
        state_n  = state;
        gnt_n    = gnt;
        last_n   = last;
        req_n    = req_q;
        oreq     = '0;
        dresp0   = '0;
        dresp1   = '0;
        busy     = 1'b0;
        pick1    = 1'b0;
        req_live = 1'b0;

        case (state)
            IDLE: begin
                // Port 0 wins when alone, or on a tie when port 1 went last.
                // oresp is deliberately ignored here: stray data_ok does nothing.
                if (dreq0.valid || dreq1.valid) begin
                    pick1   = !(dreq0.valid && (!dreq1.valid || last));
                    gnt_n   = pick1;
                    req_n   = pick1 ? dreq1 : dreq0;
                    state_n = BUSY;
                end
            end
            BUSY: begin
                busy       = 1'b1;
                // Driven only from registered state, so there is no path
                // from any dreq valid to oreq.valid.
                oreq       = req_q;
                oreq.valid = 1'b1;
                // A requester that has withdrawn (flush) gets no response;
                // the downstream access still runs to completion.
                req_live = gnt ? dreq1.valid : dreq0.valid;
                if (req_live) begin
                    if (gnt) dresp1 = oresp;
                    else     dresp0 = oresp;
                end
                if (oresp.data_ok) begin
                    state_n = IDLE;
                    last_n  = gnt;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_dbus_arbiter.sv
module tb_dbus_arbiter;
    import dbus_pkg::*;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       reset;
    dbus_req_t  dreq0, dreq1, oreq;
    dbus_resp_t dresp0, dresp1, oresp;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    dbus_arbiter #(.INIT_LAST(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .dreq0 (dreq0),
        .dresp0(dresp0),
        .dreq1 (dreq1),
        .dresp1(dresp1),
        .oreq  (oreq),
        .oresp (oresp),
        .busy  (busy)
    );

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after the rising edge; checks are made
    // after a further unit of settling, well clear of the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        dreq0 = '0;
        dreq1 = '0;
        oresp = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic set_req0(input logic v, input logic [31:0] a, input logic [2:0] sz,
                            input logic [7:0] st, input logic [63:0] d);
        dreq0.valid = v; dreq0.addr = a; dreq0.size = sz; dreq0.strobe = st; dreq0.data = d;
    endtask

    task automatic set_req1(input logic v, input logic [31:0] a, input logic [2:0] sz,
                            input logic [7:0] st, input logic [63:0] d);
        dreq1.valid = v; dreq1.addr = a; dreq1.size = sz; dreq1.strobe = st; dreq1.data = d;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        #1;
        n_checks++;
        if (oreq !== '0) $display("FAIL reset_oreq: got %h want 0", oreq); else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++;
        if (dresp0 !== '0 || dresp1 !== '0)
            $display("FAIL reset_dresp: got %h/%h want 0/0", dresp0, dresp1); else n_pass++;
    endtask

    task automatic test_single_load();
        apply_reset();
        set_req0(1'b1, 32'h8000_1000, MSIZE8, 8'h00, 64'h0);
        #1;
        n_checks++;
        if (oreq.valid !== 1'b0) $display("FAIL load_idle_valid: got %b want 0", oreq.valid); else n_pass++;
        tick(); #1;
        n_checks++;
        if (oreq.valid !== 1'b1 || oreq.addr !== 32'h8000_1000 || oreq.size !== MSIZE8)
            $display("FAIL load_oreq: got v=%b a=%h s=%0d want v=1 a=80001000 s=%0d",
                     oreq.valid, oreq.addr, oreq.size, MSIZE8); else n_pass++;
        n_checks++;
        if (busy !== 1'b1) $display("FAIL load_busy: got %b want 1", busy); else n_pass++;
        tick(); tick(); tick();
        oresp.data_ok = 1'b1;
        oresp.data    = 64'h1122_3344_5566_7788;
        #1;
        n_checks++;
        if (dresp0.data_ok !== 1'b1 || dresp0.data !== 64'h1122_3344_5566_7788)
            $display("FAIL load_dresp0: got ok=%b d=%h want ok=1 d=1122334455667788",
                     dresp0.data_ok, dresp0.data); else n_pass++;
        n_checks++;
        if (dresp1 !== '0) $display("FAIL load_dresp1: got %h want 0", dresp1); else n_pass++;
        tick();
        oresp = '0;
        dreq0 = '0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || oreq.valid !== 1'b0)
            $display("FAIL load_done: got busy=%b v=%b want 0/0", busy, oreq.valid); else n_pass++;
    endtask

    task automatic test_round_robin();
        logic [31:0] exp_addr;
        logic        exp_port;
        apply_reset();
        set_req0(1'b1, 32'h0000_0A00, MSIZE4, 8'h00, 64'h0);
        set_req1(1'b1, 32'h0000_0B00, MSIZE4, 8'h00, 64'h0);
        for (int k = 0; k < 4; k++) begin
            exp_port = k[0];
            exp_addr = exp_port ? 32'h0000_0B00 : 32'h0000_0A00;
            tick(); #1;
            n_checks++;
            if (oreq.valid !== 1'b1 || oreq.addr !== exp_addr)
                $display("FAIL rr_grant%0d: got v=%b a=%h want v=1 a=%h", k, oreq.valid, oreq.addr, exp_addr);
            else n_pass++;
            tick();
            oresp.data_ok = 1'b1;
            oresp.data    = 64'(k + 100);
            #1;
            n_checks++;
            if ((exp_port ? dresp1.data_ok : dresp0.data_ok) !== 1'b1 ||
                (exp_port ? dresp0 : dresp1) !== '0)
                $display("FAIL rr_resp%0d: got ok0=%b ok1=%b want port %0d only", k,
                         dresp0.data_ok, dresp1.data_ok, exp_port);
            else n_pass++;
            tick();
            oresp = '0;
            #1;
            n_checks++;
            if (busy !== 1'b0 || oreq.valid !== 1'b0)
                $display("FAIL rr_gap%0d: got busy=%b v=%b want 0/0", k, busy, oreq.valid);
            else n_pass++;
        end
        dreq0 = '0;
        dreq1 = '0;
        tick();
    endtask

    task automatic test_stability();
        apply_reset();
        set_req1(1'b1, 32'h0000_0010, MSIZE4, 8'h0F, 64'hDEAD_BEEF);
        tick(); #1;
        n_checks++;
        if (oreq.addr !== 32'h10 || oreq.strobe !== 8'h0F || oreq.data !== 64'hDEAD_BEEF)
            $display("FAIL store_fields: got a=%h st=%h d=%h want 10/0f/deadbeef",
                     oreq.addr, oreq.strobe, oreq.data); else n_pass++;
        dreq1.addr = 32'h0000_0020;
        tick(); #1;
        n_checks++;
        if (oreq.addr !== 32'h10) $display("FAIL store_hold: got a=%h want 10", oreq.addr); else n_pass++;
        oresp.data_ok = 1'b1;
        #1;
        n_checks++;
        if (dresp1.data_ok !== 1'b1 || oreq.addr !== 32'h10)
            $display("FAIL store_done: got ok=%b a=%h want 1/10", dresp1.data_ok, oreq.addr); else n_pass++;
        tick();
        oresp = '0;
        dreq1 = '0;
        tick();
    endtask

    task automatic test_same_cycle_rerequest();
        apply_reset();
        set_req0(1'b1, 32'h0000_0100, MSIZE4, 8'h00, 64'h0);
        tick();
        oresp.data_ok = 1'b1;
        #1;
        n_checks++;
        if (dresp0.data_ok !== 1'b1) $display("FAIL first_cycle_ok: got %b want 1", dresp0.data_ok); else n_pass++;
        tick();
        oresp = '0;
        dreq0.addr = 32'h0000_0104;
        #1;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL rereq_gap: got busy=%b want 0", busy); else n_pass++;
        tick(); #1;
        n_checks++;
        if (oreq.valid !== 1'b1 || oreq.addr !== 32'h104)
            $display("FAIL rereq_grant: got v=%b a=%h want 1/104", oreq.valid, oreq.addr); else n_pass++;
        oresp.data_ok = 1'b1;
        tick();
        oresp = '0;
        dreq0 = '0;
        tick();
    endtask

    task automatic test_abort();
        apply_reset();
        set_req0(1'b1, 32'h0000_0A00, MSIZE4, 8'h00, 64'h0);
        set_req1(1'b1, 32'h0000_0B00, MSIZE4, 8'h00, 64'h0);
        tick(); #1;
        n_checks++;
        if (oreq.addr !== 32'h0A00) $display("FAIL abort_grant0: got a=%h want a00", oreq.addr); else n_pass++;
        tick();
        dreq0.valid = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b1 || oreq.valid !== 1'b1)
            $display("FAIL abort_keep: got busy=%b v=%b want 1/1", busy, oreq.valid); else n_pass++;
        tick();
        oresp.data_ok = 1'b1;
        oresp.data    = 64'h55;
        #1;
        n_checks++;
        if (dresp0 !== '0 || dresp1 !== '0)
            $display("FAIL abort_suppress: got %h/%h want 0/0", dresp0, dresp1); else n_pass++;
        tick();
        oresp = '0;
        #1;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL abort_idle: got busy=%b want 0", busy); else n_pass++;
        tick(); #1;
        n_checks++;
        if (oreq.valid !== 1'b1 || oreq.addr !== 32'h0B00)
            $display("FAIL abort_next: got v=%b a=%h want 1/b00", oreq.valid, oreq.addr); else n_pass++;
        oresp.data_ok = 1'b1;
        tick();
        oresp = '0;
        dreq1 = '0;
        tick();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        // Complete one port-0 transaction so the pointer moves off INIT_LAST.
        set_req0(1'b1, 32'h0000_0C00, MSIZE4, 8'h00, 64'h0);
        tick();
        oresp.data_ok = 1'b1;
        tick();
        oresp = '0;
        tick();            // BUSY cycle 1 of the second transaction
        tick();            // BUSY cycle 2
        reset = 1'b1;
        tick();
        reset = 1'b0;
        dreq0 = '0;
        #1;
        n_checks++;
        if (oreq.valid !== 1'b0 || busy !== 1'b0 || dresp0 !== '0 || dresp1 !== '0)
            $display("FAIL midreset_out: got v=%b busy=%b d0=%h d1=%h want all 0",
                     oreq.valid, busy, dresp0, dresp1); else n_pass++;
        set_req0(1'b1, 32'h0000_0A00, MSIZE4, 8'h00, 64'h0);
        set_req1(1'b1, 32'h0000_0B00, MSIZE4, 8'h00, 64'h0);
        tick(); #1;
        n_checks++;
        if (oreq.addr !== 32'h0A00) $display("FAIL midreset_tie: got a=%h want a00", oreq.addr); else n_pass++;
        oresp.data_ok = 1'b1;
        tick();
        oresp = '0;
        dreq0 = '0;
        dreq1 = '0;
        tick();
    endtask

    task automatic test_spurious();
        apply_reset();
        oresp.data_ok = 1'b1;
        oresp.addr_ok = 1'b1;
        oresp.data    = 64'hABCD;
        #1;
        n_checks++;
        if (dresp0 !== '0 || dresp1 !== '0)
            $display("FAIL spur_dresp: got %h/%h want 0/0", dresp0, dresp1); else n_pass++;
        tick(); #1;
        n_checks++;
        if (busy !== 1'b0 || oreq.valid !== 1'b0)
            $display("FAIL spur_state: got busy=%b v=%b want 0/0", busy, oreq.valid); else n_pass++;
        oresp = '0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset = 1'b1;
        dreq0 = '0;
        dreq1 = '0;
        oresp = '0;
        test_reset();
        test_single_load();
        test_round_robin();
        test_stability();
        test_same_cycle_rerequest();
        test_abort();
        test_reset_mid();
        test_spurious();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
